// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit FIFO drain: FSM state encoding,
// frame geometry and line-level constants.
package uart_tx_pkg;

  // Frame sequencer states. PARITY is only reachable when the parity
  // feature is compiled in (UART_TX_PARITY_EN).
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Number of payload bits carried by one UART frame.
  localparam int FRAME_DATA_BITS = 8;

  // Line levels: the serial line rests high and a frame opens with a low bit.
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage : uart_tx_pkg

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer for the UART transmitter. On load it latches the
// effective divisor (0 is treated as 1) and restarts a down-counter;
// bit_done is high in the last cycle of every bit period.
module uart_tx_bit_timer #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic                 bit_done
);

  logic [DIV_WIDTH-1:0] eff_div;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  // Map a zero divisor onto one cycle per bit.
  always_comb begin
    eff_div = (divisor == '0) ? DIV_WIDTH'(1) : divisor;
  end

  // Next-state for the divisor latch and the remaining-cycles counter.
  // NOTE: every variable driven here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (load) begin
      div_d = eff_div;
      cnt_d = eff_div - DIV_WIDTH'(1);
    end else if (cnt_q == '0) begin
      cnt_d = div_q - DIV_WIDTH'(1);
    end else begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end
  end

  assign bit_done = (cnt_q == '0);

  // Timer registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DIV_WIDTH'(1);
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule : uart_tx_bit_timer

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining an asynchronous byte FIFO (read-clock domain).
// Pops a byte whenever the FIFO is non-empty and the transmitter is free,
// then sends start, 8 data bits LSB-first, optional parity and stop, with
// back-to-back frames while data remains.
// Optional feature: define UART_TX_PARITY_EN to build the parity bit logic;
// without it PAR_EN/PAR_TYP are ignored and every frame is 10 bits.
module uart_tx_fifo_drain
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = FRAME_DATA_BITS,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic [DIV_WIDTH-1:0]  PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  load;
  logic                  bit_done;

`ifdef UART_TX_PARITY_EN
  // Parity enable and the finished parity bit are captured at load, so
  // configuration changes mid-frame only affect the next byte.
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;
`else
  logic unused_par_cfg;
  assign unused_par_cfg = PAR_EN ^ PAR_TYP;
`endif

  uart_tx_bit_timer #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_bit_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (load),
    .divisor  (PRESCALE),
    .bit_done (bit_done)
  );

  // Decide whether a byte is taken this cycle: from IDLE immediately, or
  // on the last stop-bit cycle so the next start bit follows with no gap.
  always_comb begin
    load = 1'b0;
    case (state_q)
      IDLE:    load = !rempty;
      STOP:    load = bit_done && !rempty;
      default: load = 1'b0;
    endcase
  end

  // The pop strobe is the load decision itself: the FIFO advances on the
  // same edge that captures rdata. Reset holds it low so no byte is lost.
  assign rinc = load && !RST;

  // Frame sequencer next-state, shift register and bit index.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif
    if (load) begin
      state_d = START;
      shift_d = rdata;
      idx_d   = '0;
`ifdef UART_TX_PARITY_EN
      par_en_d  = PAR_EN;
      par_bit_d = (^rdata) ^ PAR_TYP;
`endif
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        START: begin
          if (bit_done) state_d = DATA;
        end
        DATA: begin
          if (bit_done) begin
            shift_d = shift_q >> 1;
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
`ifdef UART_TX_PARITY_EN
              state_d = par_en_q ? PARITY : STOP;
`else
              state_d = STOP;
`endif
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) state_d = STOP;
        end
`endif
        STOP: begin
          if (bit_done) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Line level and busy flag for the coming cycle, decoded from the next
  // state so both leave the block straight from flops.
  always_comb begin
    tx_d   = LINE_IDLE;
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = LINE_START;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_bit_d;
`endif
      default: tx_d = LINE_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset; a reset mid-frame
  // abandons the byte in flight and returns the line to idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= LINE_IDLE;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule : uart_tx_fifo_drain

// File: tb/tb_uart_tx_fifo_drain.sv
// Self-checking bench for uart_tx_fifo_drain. A simple FIFO model feeds
// bytes; expected line levels are built per byte from the frame rules
// (start, data LSB-first, optional parity, stop, each DIV cycles long).
module tb_uart_tx_fifo_drain;
  import uart_tx_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;
  logic [7:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic       tx_out;
  logic       busy;

  // FIFO model: written by the stimulus, popped by rinc.
  logic [7:0] mem [64];
  logic [5:0] wr_ptr;
  logic [5:0] rd_ptr;
  int         pop_count;

  int n_checks;
  int n_err;

  logic [7:0] exp_bytes[$];

  uart_tx_fifo_drain dut (
    .CLK      (clk),
    .RST      (rst),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .PRESCALE (prescale),
    .PAR_EN   (par_en),
    .PAR_TYP  (par_typ),
    .TX_OUT   (tx_out),
    .BUSY     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign rempty = (rd_ptr == wr_ptr);
  assign rdata  = mem[rd_ptr];

  initial begin
    rd_ptr    = '0;
    pop_count = 0;
  end

  always @(posedge clk) begin
    if (rinc) begin
      rd_ptr    <= rd_ptr + 6'd1;
      pop_count <= pop_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_all();
    foreach (exp_bytes[i]) begin
      mem[wr_ptr] = exp_bytes[i];
      wr_ptr      = wr_ptr + 6'd1;
    end
  endtask

  function automatic int eff_div(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  // Called at a falling edge with exp_bytes already in the FIFO and the DUT
  // idle. PRESCALE is p_first for the first load and switches to p_rest
  // during the first start bit.
  task automatic check_stream(input int p_first, input int p_rest,
                              input logic pen, input logic ptyp);
    int pops_before;
    int n;
    prescale    = 8'(p_first);
    par_en      = pen;
    par_typ     = ptyp;
    pops_before = pop_count;
    n           = exp_bytes.size();
    #1;
    check("first_pop", rinc, 1'b1);
    check("first_tx_idle", tx_out, 1'b1);
    for (int f = 0; f < n; f++) begin
      logic [7:0] b;
      int d;
      int nb;
      b  = exp_bytes[f];
      d  = eff_div((f == 0) ? p_first : p_rest);
      nb = (PARITY_ON && pen) ? 11 : 10;
      for (int k = 0; k < nb; k++) begin
        logic ebit;
        if (k == 0)                  ebit = 1'b0;
        else if (k <= 8)             ebit = b[k-1];
        else if (k == 9 && nb == 11) ebit = (^b) ^ ptyp;
        else                         ebit = 1'b1;
        for (int r = 0; r < d; r++) begin
          @(negedge clk);
          if (f == 0 && k == 0 && r == 0) prescale = 8'(p_rest);
          check($sformatf("f%0d_bit%0d_c%0d_tx", f, k, r), tx_out, ebit);
          check($sformatf("f%0d_bit%0d_c%0d_busy", f, k, r), busy, 1'b1);
          check($sformatf("f%0d_bit%0d_c%0d_rinc", f, k, r), rinc,
                (k == nb - 1 && r == d - 1 && f < n - 1));
        end
      end
    end
    @(negedge clk);
    check("end_busy", busy, 1'b0);
    check("end_tx", tx_out, 1'b1);
    check("end_rinc", rinc, 1'b0);
    check("pop_total", pop_count - pops_before, n);
  endtask

  initial begin
    int p0;
    n_checks = 0;
    n_err    = 0;
    wr_ptr   = '0;
    rst      = 1'b1;
    prescale = 8'd4;
    par_en   = 1'b0;
    par_typ  = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rinc", rinc, 1'b0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;

    // Idle with an empty FIFO.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_rinc", rinc, 1'b0);
      check("idle_tx", tx_out, 1'b1);
      check("idle_busy", busy, 1'b0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle_rst_tx", tx_out, 1'b1);
    check("idle_rst_busy", busy, 1'b0);
    check("idle_rst_rinc", rinc, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single byte, parity off.
    exp_bytes = '{8'hA5};
    push_all();
    check_stream(4, 4, 1'b0, 1'b0);

    // Parity even then odd (10-bit frames if parity is not built).
    exp_bytes = '{8'hA5};
    push_all();
    check_stream(4, 4, 1'b1, 1'b0);
    exp_bytes = '{8'hA5};
    push_all();
    check_stream(4, 4, 1'b1, 1'b1);

    // Back-to-back frames at one cycle per bit.
    exp_bytes = '{8'h01, 8'hFF, 8'h3C};
    push_all();
    check_stream(1, 1, 1'b0, 1'b0);

    // Divisor 0 behaves as 1.
    exp_bytes = '{8'h96};
    push_all();
    check_stream(0, 0, 1'b0, 1'b0);

    // Divisor change mid-frame applies to the next frame only.
    exp_bytes = '{8'hC3, 8'h5A};
    push_all();
    check_stream(4, 2, 1'b0, 1'b0);

    // Reset during data bit 3; a queued byte must wait, the aborted one is
    // not re-read.
    p0        = pop_count;
    exp_bytes = '{8'hA5};
    prescale  = 8'd4;
    par_en    = 1'b0;
    push_all();
    repeat (18) @(negedge clk);
    check("mid_bit3_tx", tx_out, 1'b0);
    check("mid_bit3_busy", busy, 1'b1);
    exp_bytes = '{8'h5A};
    push_all();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_tx", tx_out, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    check("mid_rst_rinc", rinc, 1'b0);
    check("mid_rst_pops", pop_count - p0, 1);
    @(negedge clk);
    rst = 1'b0;
    check_stream(4, 4, 1'b0, 1'b0);

    // Randomized batches.
    for (int t = 0; t < 8; t++) begin
      int n;
      int p1;
      int p2;
      logic pe;
      logic pt;
      n  = int'($urandom_range(1, 4));
      p1 = int'($urandom_range(0, 5));
      p2 = int'($urandom_range(0, 5));
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      exp_bytes.delete();
      for (int i = 0; i < n; i++) exp_bytes.push_back(8'($urandom));
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
      push_all();
      check_stream(p1, p2, pe, pt);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_uart_tx_fifo_drain
